// File: rtl/sdram_pkg.sv
// Shared state encodings, SDRAM opcodes and the command-word builder for sdram_cmd_seq.
package sdram_pkg;

  localparam logic [4:0] S_INIT_WAIT = 5'd0;
  localparam logic [4:0] S_PRE       = 5'd1;
  localparam logic [4:0] S_PRE_WAIT  = 5'd2;
  localparam logic [4:0] S_REF       = 5'd3;
  localparam logic [4:0] S_REF_WAIT  = 5'd4;
  localparam logic [4:0] S_MRS       = 5'd5;
  localparam logic [4:0] S_MRS_WAIT  = 5'd6;
  localparam logic [4:0] S_IDLE      = 5'd7;
  localparam logic [4:0] S_RPRE      = 5'd8;
  localparam logic [4:0] S_RPRE_WAIT = 5'd9;
  localparam logic [4:0] S_RREF      = 5'd10;
  localparam logic [4:0] S_RREF_WAIT = 5'd11;
  localparam logic [4:0] S_ACT       = 5'd12;
  localparam logic [4:0] S_ACT_WAIT  = 5'd13;
  localparam logic [4:0] S_RD        = 5'd14;
  localparam logic [4:0] S_RD_WAIT   = 5'd15;
  localparam logic [4:0] S_WR        = 5'd16;
  localparam logic [4:0] S_WR_WAIT   = 5'd17;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] OP_NOP = 3'b111;
  localparam logic [2:0] OP_PRE = 3'b010;
  localparam logic [2:0] OP_REF = 3'b001;
  localparam logic [2:0] OP_MRS = 3'b000;
  localparam logic [2:0] OP_ACT = 3'b011;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_WR  = 3'b100;

  localparam int MAX_BANK_W = 8;
  localparam int CMD_MAX_W  = MAX_BANK_W + 6;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Packs {cke=1, cs_n=0, op, ba[bank_w-1:0], a10} into the low bits; callers truncate to their width.
  function automatic logic [CMD_MAX_W-1:0] cmd_word(input logic [2:0] op,
                                                   input logic [MAX_BANK_W-1:0] ba,
                                                   input logic a10,
                                                   input int bank_w);
    logic [CMD_MAX_W-1:0] w;
    w = {{(CMD_MAX_W-5){1'b0}}, 2'b10, op};
    w = (w << (bank_w + 1)) | ({{(CMD_MAX_W-MAX_BANK_W){1'b0}}, ba} << 1)
        | {{(CMD_MAX_W-1){1'b0}}, a10};
    return w;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Saturating refresh-interval timer; refresh_due is high while the timer sits at its limit.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 519
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  output logic refresh_due
);

  localparam int TW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [TW-1:0] LIMIT = TW'(REFRESH_INTERVAL);

  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_nx_s;
  logic          due_r;

  // next timer value: clear wins over counting, counting stops at the limit
  always_comb begin
    timer_nx_s = timer_r;
    if (clr) begin
      timer_nx_s = '0;
    end else if (timer_r != LIMIT) begin
      timer_nx_s = timer_r + TW'(1);
    end else begin
      timer_nx_s = timer_r;
    end
  end

  // timer and due flag registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      timer_r <= '0;
      due_r   <= 1'b0;
    end else begin
      timer_r <= timer_nx_s;
      due_r   <= (timer_nx_s == LIMIT);
    end
  end

  assign refresh_due = due_r;

endmodule

// File: rtl/sdram_cmd_seq.sv
// SDRAM command sequencer: power-up init, periodic auto-refresh and single-beat
// read/write with auto-precharge; cmd is registered and always matches state.
module sdram_cmd_seq
  import sdram_pkg::*;
#(
  parameter int INIT_CYCLES      = 16,
  parameter int T_RP             = 2,
  parameter int T_RFC            = 8,
  parameter int T_MRD            = 2,
  parameter int T_RCD            = 2,
  parameter int T_CAS            = 2,
  parameter int T_WR             = 2,
  parameter int INIT_REFRESHES   = 2,
  parameter int REFRESH_INTERVAL = 519,
  parameter int BANK_W           = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                rd_enable,
  input  logic                wr_enable,
  input  logic [BANK_W-1:0]   bank,
  output logic                ack,
  output logic                rd_valid,
  output logic                init_done,
  output logic                refresh_due,
  output logic [BANK_W+5:0]   cmd,
  output logic [4:0]          state
);

  localparam int CMD_W = BANK_W + 6;
  localparam int MAX_T = max_of(max_of(max_of(INIT_CYCLES, T_RFC), max_of(T_CAS + T_RP, T_WR + T_RP)),
                                max_of(max_of(T_MRD, T_RCD), INIT_REFRESHES));
  localparam int CNT_W = $clog2(MAX_T) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  logic [4:0]        state_r;
  logic [4:0]        state_nx;
  cnt_t              cnt_r;
  cnt_t              iref_r;
  logic              cnt_zero_s;
  logic              accept_s;
  logic              ref_issue_s;
  logic [BANK_W-1:0] bank_r;
  logic [BANK_W-1:0] bank_nx_s;
  logic              is_wr_r;
  logic [T_CAS-1:0]  rd_pipe_r;
  logic [2:0]        op_s;
  logic [BANK_W-1:0] ba_s;
  logic              a10_s;
  logic [CMD_W-1:0]  cmd_nx_s;
  logic [CMD_W-1:0]  cmd_r;
  logic              ack_r;
  logic              init_done_r;

  assign cnt_zero_s  = (cnt_r == '0);
  assign accept_s    = (state_r == S_IDLE) && (state_nx == S_ACT);
  assign bank_nx_s   = accept_s ? bank : bank_r;
  assign ref_issue_s = (state_r == S_REF) || (state_r == S_RREF);

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .CLK         (CLK),
    .RESET       (RESET),
    .clr         (ref_issue_s),
    .refresh_due (refresh_due)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= S_INIT_WAIT;
    end else begin
      state_r <= state_nx;
    end
  end

  // next-state logic; IDLE priority is refresh, then read, then write
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_INIT_WAIT: if (cnt_zero_s) state_nx = S_PRE;       else state_nx = S_INIT_WAIT;
      S_PRE:                       state_nx = S_PRE_WAIT;
      S_PRE_WAIT:  if (cnt_zero_s) state_nx = S_REF;       else state_nx = S_PRE_WAIT;
      S_REF:                       state_nx = S_REF_WAIT;
      S_REF_WAIT: begin
        if (!cnt_zero_s)           state_nx = S_REF_WAIT;
        else if (iref_r == '0)     state_nx = S_MRS;
        else                       state_nx = S_REF;
      end
      S_MRS:                       state_nx = S_MRS_WAIT;
      S_MRS_WAIT:  if (cnt_zero_s) state_nx = S_IDLE;      else state_nx = S_MRS_WAIT;
      S_IDLE: begin
        if (refresh_due)                   state_nx = S_RPRE;
        else if (rd_enable || wr_enable)   state_nx = S_ACT;
        else                               state_nx = S_IDLE;
      end
      S_RPRE:                      state_nx = S_RPRE_WAIT;
      S_RPRE_WAIT: if (cnt_zero_s) state_nx = S_RREF;      else state_nx = S_RPRE_WAIT;
      S_RREF:                      state_nx = S_RREF_WAIT;
      S_RREF_WAIT: if (cnt_zero_s) state_nx = S_IDLE;      else state_nx = S_RREF_WAIT;
      S_ACT:                       state_nx = S_ACT_WAIT;
      S_ACT_WAIT: begin
        if (!cnt_zero_s)           state_nx = S_ACT_WAIT;
        else if (is_wr_r)          state_nx = S_WR;
        else                       state_nx = S_RD;
      end
      S_RD:                        state_nx = S_RD_WAIT;
      S_RD_WAIT:   if (cnt_zero_s) state_nx = S_IDLE;      else state_nx = S_RD_WAIT;
      S_WR:                        state_nx = S_WR_WAIT;
      S_WR_WAIT:   if (cnt_zero_s) state_nx = S_IDLE;      else state_nx = S_WR_WAIT;
      default:                     state_nx = S_INIT_WAIT;
    endcase
  end

  // command decode for the state being entered, so the registered cmd lines up with state
  always_comb begin
    op_s  = OP_NOP;
    ba_s  = '0;
    a10_s = 1'b0;
    case (state_nx)
      S_PRE, S_RPRE: begin op_s = OP_PRE; a10_s = 1'b1; end
      S_REF, S_RREF: op_s = OP_REF;
      S_MRS:         op_s = OP_MRS;
      S_ACT:   begin op_s = OP_ACT; ba_s = bank_nx_s; end
      S_RD:    begin op_s = OP_RD;  ba_s = bank_nx_s; a10_s = 1'b1; end
      S_WR:    begin op_s = OP_WR;  ba_s = bank_nx_s; a10_s = 1'b1; end
      default:       op_s = OP_NOP;
    endcase
    cmd_nx_s = CMD_W'(cmd_word(op_s, MAX_BANK_W'(ba_s), a10_s, BANK_W));
  end

  // wait counter is loaded with T-2 on each issue cycle, giving T-1 NOPs before the next command
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_r  <= cnt_t'(INIT_CYCLES - 1);
      iref_r <= cnt_t'(INIT_REFRESHES - 1);
    end else begin
      case (state_r)
        S_PRE, S_RPRE: cnt_r <= cnt_t'(T_RP - 2);
        S_REF, S_RREF: cnt_r <= cnt_t'(T_RFC - 2);
        S_MRS:         cnt_r <= cnt_t'(T_MRD - 2);
        S_ACT:         cnt_r <= cnt_t'(T_RCD - 2);
        S_RD:          cnt_r <= cnt_t'(T_CAS + T_RP - 2);
        S_WR:          cnt_r <= cnt_t'(T_WR + T_RP - 2);
        default: begin
          if (!cnt_zero_s) cnt_r <= cnt_r - cnt_t'(1);
          else             cnt_r <= cnt_r;
        end
      endcase
      if (state_r == S_REF_WAIT && cnt_zero_s && iref_r != '0) begin
        iref_r <= iref_r - cnt_t'(1);
      end else begin
        iref_r <= iref_r;
      end
    end
  end

  // request latch and CAS-latency pipe for rd_valid
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bank_r    <= '0;
      is_wr_r   <= 1'b0;
      rd_pipe_r <= '0;
    end else begin
      bank_r    <= bank_nx_s;
      if (accept_s) is_wr_r <= !rd_enable;
      else          is_wr_r <= is_wr_r;
      rd_pipe_r <= T_CAS'({rd_pipe_r, state_r == S_RD});
    end
  end

  // registered outputs
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cmd_r       <= CMD_W'(cmd_word(OP_NOP, '0, 1'b0, BANK_W));
      ack_r       <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      cmd_r       <= cmd_nx_s;
      ack_r       <= (state_nx == S_ACT);
      init_done_r <= init_done_r || (state_nx == S_IDLE);
    end
  end

  assign cmd       = cmd_r;
  assign ack       = ack_r;
  assign init_done = init_done_r;
  assign rd_valid  = rd_pipe_r[T_CAS-1];
  assign state     = state_r;

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// Bench for sdram_cmd_seq: directed scenarios plus random traffic, checked against a
// command-stream model that expands each accepted operation into its expected cmd sequence.
module tb_sdram_cmd_seq;

  localparam int INIT_CYC = 16;
  localparam int TRP      = 2;
  localparam int TRFC     = 8;
  localparam int TMRD     = 2;
  localparam int TRCD     = 2;
  localparam int TCAS     = 2;
  localparam int TWR      = 2;
  localparam int IREF     = 2;
  localparam int RINT     = 519;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       rd_enable, wr_enable;
  logic [1:0] bank;
  logic       ack, rd_valid, init_done, refresh_due;
  logic [7:0] cmd;
  logic [4:0] state;

  sdram_cmd_seq dut (
    .CLK(CLK), .RESET(RESET), .rd_enable(rd_enable), .wr_enable(wr_enable), .bank(bank),
    .ack(ack), .rd_valid(rd_valid), .init_done(init_done), .refresh_due(refresh_due),
    .cmd(cmd), .state(state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] mk(input logic [2:0] op, input logic [1:0] ba, input logic a10);
    return {1'b1, 1'b0, op, ba, a10};
  endfunction

  localparam logic [7:0] NOP_W = 8'hB8;
  localparam logic [7:0] PRE_W = 8'h91;
  localparam logic [7:0] REF_W = 8'h88;
  localparam logic [7:0] MRS_W = 8'h80;

  typedef struct {
    logic [7:0] c;
    bit         a;
    int         tag;   // 1 = read accepted, 2 = write accepted
  } ent_t;

  ent_t q[$];
  int   vq[$];
  int   cyc, tm_m;
  bit   done_m;
  bit   rd_req, wr_req, rand_mode;
  int   bank_fix;
  int   n_cmp, n_fail, ack_cnt;
  ent_t last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] c, input bit a, input int tag);
    ent_t e;
    e.c = c; e.a = a; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic push_nops(input int n);
    for (int i = 0; i < n; i++) push(NOP_W, 1'b0, 0);
  endtask

  // One clock cycle: check the current cycle, advance the model, drive next inputs.
  task automatic step();
    ent_t e;
    bit   idle, ev, due_cur;
    idle = (q.size() == 0);
    if (idle) begin
      e.c = NOP_W; e.a = 1'b0; e.tag = 0;
      done_m = 1'b1;
    end else begin
      e = q.pop_front();
    end
    ev = (vq.size() > 0 && vq[0] == cyc);
    if (ev) void'(vq.pop_front());
    due_cur = (tm_m == RINT);
    chk("cmd", 32'(cmd), 32'(e.c));
    chk("ack", 32'(ack), 32'(e.a));
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    chk("init_done", 32'(init_done), 32'(done_m));
    chk("refresh_due", 32'(refresh_due), 32'(due_cur));
    if (ack === 1'b1) ack_cnt++;
    last = e;
    if (e.c[5:3] == 3'b101) vq.push_back(cyc + TCAS);
    if (e.c[5:3] == 3'b001) tm_m = 0;
    else if (tm_m < RINT)   tm_m = tm_m + 1;
    if (e.tag == 1) rd_req = 1'b0;
    if (e.tag == 2) wr_req = 1'b0;
    if (rand_mode) begin
      if (!rd_req && $urandom_range(0, 5) == 0) rd_req = 1'b1;
      if (!wr_req && $urandom_range(0, 5) == 0) wr_req = 1'b1;
    end
    rd_enable = rd_req;
    wr_enable = wr_req;
    bank = (bank_fix < 0) ? 2'($urandom_range(0, 3)) : 2'(bank_fix);
    if (idle) begin
      if (due_cur) begin
        push(PRE_W, 1'b0, 0); push_nops(TRP - 1);
        push(REF_W, 1'b0, 0); push_nops(TRFC - 1);
      end else if (rd_req) begin
        push(mk(3'b011, bank, 1'b0), 1'b1, 1); push_nops(TRCD - 1);
        push(mk(3'b101, bank, 1'b1), 1'b0, 0); push_nops(TCAS + TRP - 1);
      end else if (wr_req) begin
        push(mk(3'b011, bank, 1'b0), 1'b1, 2); push_nops(TRCD - 1);
        push(mk(3'b100, bank, 1'b1), 1'b0, 0); push_nops(TWR + TRP - 1);
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  // Hold reset for n edges, checking reset outputs, then load the expected init sequence.
  task automatic do_reset(input int n);
    RESET = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0;
    rd_enable = 1'b0; wr_enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i < n - 1) begin
        chk("rst_cmd", 32'(cmd), 32'(NOP_W));
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_refresh_due", 32'(refresh_due), 32'd0);
      end
    end
    RESET = 1'b1;
    q.delete(); vq.delete();
    tm_m = 0; done_m = 1'b0; cyc = 0;
    push_nops(INIT_CYC);
    push(PRE_W, 1'b0, 0); push_nops(TRP - 1);
    for (int r = 0; r < IREF; r++) begin
      push(REF_W, 1'b0, 0); push_nops(TRFC - 1);
    end
    push(MRS_W, 1'b0, 0); push_nops(TMRD - 1);
  endtask

  initial begin
    bit found, seen_rv, got;
    n_cmp = 0; n_fail = 0; ack_cnt = 0;
    rand_mode = 1'b0; bank_fix = 0;
    bank = 2'd0;

    // init sequence after reset
    do_reset(5);
    repeat (45) step();

    // single read to bank 2
    bank_fix = 2;
    rd_req = 1'b1;
    repeat (12) step();

    // simultaneous read and write: read first, then the write, two acks
    bank_fix = -1;
    ack_cnt = 0;
    rd_req = 1'b1; wr_req = 1'b1;
    repeat (25) step();
    chk("two_acks", 32'(ack_cnt), 32'd2);

    // periodic refresh while idle
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      if (cmd === PRE_W) found = 1'b1;
      step();
    end
    chk("refresh_seen", 32'(found), 32'd1);
    repeat (12) step();

    // refresh timer expires during the read; refresh must precede the pending write
    for (int i = 0; i < 700 && tm_m < RINT - 6; i++) step();
    rd_req = 1'b1; wr_req = 1'b1;
    seen_rv = 1'b0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (seen_rv && !got && cmd !== NOP_W) begin
        got = 1'b1;
        chk("refresh_before_write", 32'(cmd), 32'(PRE_W));
      end
      if (rd_valid === 1'b1) seen_rv = 1'b1;
      step();
    end
    chk("refresh_after_read_seen", 32'(got), 32'd1);

    // reset during ACT_WAIT, then the full init reruns
    rd_req = 1'b1;
    last.a = 1'b0;
    for (int i = 0; i < 30 && !last.a; i++) step();
    chk("act_reached", 32'(last.a), 32'd1);
    do_reset(3);
    repeat (45) step();

    // random traffic
    rand_mode = 1'b1;
    repeat (4000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
